// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin resource arbiter slice.
//   arb_state_t        : arbiter FSM state encoding (idle / owned)
//   ARB_MIN_REQUESTERS : smallest legal client count
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  localparam int ARB_MIN_REQUESTERS = 2;

endpackage : arb_pkg

// File: rtl/generic_mux.sv
// Generic N:1 data mux with enable; output is zero when disabled.
//   data : unpacked array of INPUTS words, WIDTH bits each
//   sel  : index of the word to forward
//   en   : forward enable, output forced to 0 when low
//   dout : selected word
// The loop compare keeps out-of-range selects (non power-of-two INPUTS) at zero.
module generic_mux #(
  parameter  int INPUTS = 4,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic [WIDTH-1:0] data [INPUTS],
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = '0;
    if (en) begin
      for (int i = 0; i < INPUTS; i++) begin
        if (sel == SEL_W'(i)) dout = data[i];
      end
    end
  end

endmodule : generic_mux

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (combinational).
//   mask  : candidate bits
//   ptr   : index of the most recent winner; search starts at ptr+1
//   found : at least one candidate bit is set
//   idx   : first set bit at or after ptr+1, with wrap-around
module rr_priority_pick #(
  parameter  int REQUESTERS = 4,
  localparam int IDX_W      = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] mask,
  input  logic [IDX_W-1:0]      ptr,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  int cand;

  // Offsets run 1..REQUESTERS so the last-granted index is checked last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = 1; off <= REQUESTERS; off++) begin
      cand = (int'(ptr) + off) % REQUESTERS;
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule : rr_priority_pick

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one downstream resource between REQUESTERS clients.
//   clock     : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   req       : per-client request levels
//   req_data  : per-client payloads
//   res_done  : resource finished with the current owner (pulse)
//   gnt       : registered one-hot grant, zero when idle
//   owner     : index of the current owner, valid while busy
//   busy      : a grant is active
//   res_valid : payload on res_data is valid (same as busy)
//   res_data  : owner's payload while busy, else zero
//   timeout   : one-cycle pulse after a watchdog-forced release
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | no owner; any request is granted on the next edge
// ARB_OWNED | gnt one-hot; hold counts cycles until a release condition
module rr_resource_arbiter
  import arb_pkg::*;
#(
  parameter  int REQUESTERS = 4,
  parameter  int WIDTH      = 8,
  parameter  int MAX_HOLD   = 16,
  localparam int IDX_W      = $clog2(REQUESTERS),
  localparam int HOLD_W     = $clog2(MAX_HOLD)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REQUESTERS-1:0] req,
  input  logic [WIDTH-1:0]      req_data [REQUESTERS],
  input  logic                  res_done,
  output logic [REQUESTERS-1:0] gnt,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic                  timeout
);

  generate
    if (REQUESTERS < ARB_MIN_REQUESTERS) begin : g_bad_requesters
      $error("rr_resource_arbiter: REQUESTERS must be >= %0d", ARB_MIN_REQUESTERS);
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
      $error("rr_resource_arbiter: MAX_HOLD must be >= 2");
    end
  endgenerate

  arb_state_t            state;
  logic [IDX_W-1:0]      ptr;
  logic [HOLD_W-1:0]     hold;

  logic                  owner_req;
  logic                  hold_max;
  logic                  forced;
  logic                  release_now;
  logic                  arbitrate;
  logic [REQUESTERS-1:0] cand_mask;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [REQUESTERS-1:0] win_onehot;

  assign owner_req = req[owner];
  assign hold_max  = (hold == HOLD_W'(MAX_HOLD - 1));

  // Watchdog only fires when neither normal release condition holds.
  assign forced      = (state == ARB_OWNED) && !res_done && owner_req && hold_max;
  assign release_now = (state == ARB_OWNED) && (res_done || !owner_req || hold_max);
  assign arbitrate   = (state == ARB_IDLE) || release_now;

  // gnt is one-hot on the owner while OWNED, so masking with it drops only the
  // timed-out owner from this one arbitration.
  assign cand_mask = forced ? (req & ~gnt) : req;

  rr_priority_pick #(
    .REQUESTERS (REQUESTERS)
  ) u_pick (
    .mask  (cand_mask),
    .ptr   (ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  assign win_onehot = REQUESTERS'(1) << win_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARB_IDLE;
      gnt     <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      hold    <= '0;
      ptr     <= IDX_W'(REQUESTERS - 1);
    end else begin
      timeout <= forced;
      if (arbitrate) begin
        hold <= '0;
        if (win_found) begin
          state <= ARB_OWNED;
          gnt   <= win_onehot;
          owner <= win_idx;
          ptr   <= win_idx;
          busy  <= 1'b1;
        end else begin
          state <= ARB_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      end else begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end

  assign res_valid = busy;

  generic_mux #(
    .INPUTS (REQUESTERS),
    .WIDTH  (WIDTH)
  ) u_data_mux (
    .data (req_data),
    .sel  (owner),
    .en   (busy),
    .dout (res_data)
  );

endmodule : rr_resource_arbiter

// File: tb/tb_rr_resource_arbiter.sv
module tb_rr_resource_arbiter;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] req_data [4];
  logic       res_done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_data;
  logic       timeout;

  int tests_run;
  int tests_failed;

  rr_resource_arbiter #(
    .REQUESTERS (4),
    .WIDTH      (8),
    .MAX_HOLD   (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .res_done  (res_done),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .res_valid (res_valid),
    .res_data  (res_data),
    .timeout   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  // Leaves time at a negedge with reset released; next posedge is the first live edge.
  task automatic apply_reset(input logic [3:0] r);
    req      = r;
    res_done = 1'b0;
    reset_n  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    req      = 4'b1111;
    res_done = 1'b0;
    reset_n  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: gnt=%b expected 0000", gnt); end
    tests_run++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: busy=%b res_valid=%b expected 0 0", busy, res_valid); end
    tests_run++;
    if (res_data !== 8'h00) begin tests_failed++; $display("FAIL reset_res_data: res_data=%h expected 00", res_data); end
    tests_run++;
    if (timeout !== 1'b0 || owner !== 2'd0) begin tests_failed++; $display("FAIL reset_timeout_owner: timeout=%b owner=%0d expected 0 0", timeout, owner); end
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin tests_failed++; $display("FAIL reset_first_gnt: gnt=%b owner=%0d busy=%b expected 0001 0 1", gnt, owner, busy); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset(4'b1111);
    res_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (gnt !== exp_seq[i] || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rotation_step%0d: gnt=%b busy=%b expected %b 1", i, gnt, busy, exp_seq[i]);
      end
    end
    res_done = 1'b0;
    req      = 4'b0000;
  endtask

  task automatic test_timeout();
    apply_reset(4'b0100);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_hold%0d: gnt=%b timeout=%b expected 0100 0", i, gnt, timeout);
      end
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_forced: gnt=%b timeout=%b busy=%b expected 0000 1 0", gnt, timeout, busy); end
    tick();
    tests_run++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_regrant: gnt=%b timeout=%b expected 0100 0", gnt, timeout); end
    req = 4'b0000;
  endtask

  task automatic test_timeout_handoff();
    apply_reset(4'b0101);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL handoff_hold%0d: gnt=%b expected 0001", i, gnt); end
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || timeout !== 1'b1) begin tests_failed++; $display("FAIL handoff_forced: gnt=%b owner=%0d timeout=%b expected 0100 2 1", gnt, owner, timeout); end
    tick();
    tests_run++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin tests_failed++; $display("FAIL handoff_pulse_end: gnt=%b timeout=%b expected 0100 0", gnt, timeout); end
    req = 4'b0000;
  endtask

  task automatic test_idle_done_ignored();
    apply_reset(4'b0000);
    res_done = 1'b1;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || timeout !== 1'b0) begin tests_failed++; $display("FAIL idle_done: busy=%b gnt=%b timeout=%b expected 0 0000 0", busy, gnt, timeout); end
    res_done = 1'b0;
  endtask

  task automatic test_drop_req();
    apply_reset(4'b1010);
    tick();
    tests_run++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin tests_failed++; $display("FAIL drop_first: gnt=%b owner=%0d expected 0010 1", gnt, owner); end
    req = 4'b1000;
    tick();
    tests_run++;
    if (gnt !== 4'b1000 || owner !== 2'd3 || timeout !== 1'b0) begin tests_failed++; $display("FAIL drop_handoff: gnt=%b owner=%0d timeout=%b expected 1000 3 0", gnt, owner, timeout); end
    req = 4'b0000;
  endtask

  task automatic test_payload();
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    req_data[2] = 8'hA5;
    req_data[3] = 8'h44;
    apply_reset(4'b0100);
    tests_run++;
    if (res_data !== 8'h00 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL payload_idle: res_data=%h res_valid=%b expected 00 0", res_data, res_valid); end
    tick();
    tests_run++;
    if (res_valid !== 1'b1 || res_data !== 8'hA5 || owner !== 2'd2) begin tests_failed++; $display("FAIL payload_owner2: res_valid=%b res_data=%h owner=%0d expected 1 a5 2", res_valid, res_data, owner); end
    req = 4'b0000;
    tick();
    tests_run++;
    if (busy !== 1'b0 || res_data !== 8'h00) begin tests_failed++; $display("FAIL payload_release: busy=%b res_data=%h expected 0 00", busy, res_data); end
    req = 4'b0001;
    tick();
    tests_run++;
    if (res_data !== 8'h11 || owner !== 2'd0) begin tests_failed++; $display("FAIL payload_owner0: res_data=%h owner=%0d expected 11 0", res_data, owner); end
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    apply_reset(4'b1000);
    tick();
    tests_run++;
    if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL async_pre: gnt=%b expected 1000", gnt); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL async_clear: gnt=%b busy=%b res_valid=%b expected 0000 0 0", gnt, busy, res_valid); end
    req = 4'b1001;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin tests_failed++; $display("FAIL async_first: gnt=%b owner=%0d expected 0001 0", gnt, owner); end
    req = 4'b0000;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    req          = 4'b0000;
    res_done     = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i] = 8'h00;

    test_reset();
    test_rotation();
    test_timeout();
    test_timeout_handoff();
    test_idle_done_ignored();
    test_drop_req();
    test_payload();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_rr_resource_arbiter
